subword_scheduler: RTL and testbench

// Time-shares one 32-bit S-box word unit (4 parallel byte S-boxes) between two AES requesters.
// - Key-expansion port: one 32-bit SubWord per request.
// - Cipher-round port: a full 128-bit SubBytes, issued as 4 sequential word passes.

---
 rtl/subword_scheduler_pkg.sv | 26 ++
 rtl/subword_scheduler_sbox.sv | 33 +++
 rtl/subword_scheduler.sv | 142 ++++++++++++++
 tb/tb_subword_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subword_scheduler_pkg.sv
// Shared definitions for the S-box word-unit scheduler: widths, FSM encoding
// and the GF(2^8) multiply used to build the byte S-box.
package subword_scheduler_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_STATE_W = 128;
  localparam int AES_NWORDS  = 4;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_KS   = 2'd1;
  localparam logic [1:0] FSM_ST   = 2'd2;

  // Multiply in GF(2^8) modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/subword_scheduler_sbox.sv
// Combinational 32-bit S-box word unit: four byte S-boxes, each a GF(2^8)
// inversion (x^254, zero maps to zero) followed by the AES affine transform.
module subword_scheduler_sbox
  import subword_scheduler_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word_i,
  output logic [AES_WORD_W-1:0] word_o
);

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    word_o = '0;
    for (int i = 0; i < AES_WORD_W / 8; i++) begin
      word_o[8*i +: 8] = sbox_byte(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/subword_scheduler.sv
// Shares one S-box word unit between the key-expansion port (one SubWord per
// request) and the cipher port (SubBytes as four sequential word passes).
module subword_scheduler
  import subword_scheduler_pkg::*;
#(
  parameter logic KS_STRICT_PRI = 1'b0,
  parameter logic RR_INIT       = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ks_req_valid,
  output logic         ks_req_ready,
  input  logic [31:0]  ks_word,
  output logic         ks_rsp_valid,
  output logic [31:0]  ks_rsp_word,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_state,
  output logic         st_rsp_valid,
  output logic [127:0] st_rsp_state,
  output logic         busy
);

  // Handshake: a request transfers on a rising edge where valid & ready.
  // Ready is only ever high in IDLE and only for the arbitration winner; the
  // losing requester must hold valid and data stable until it is granted.

  logic [1:0]             state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic                   rr_q, rr_d;
  logic [AES_WORD_W-1:0]  ks_op_q, ks_op_d;
  logic [AES_STATE_W-1:0] st_buf_q, st_buf_d;
  logic [AES_WORD_W-1:0]  ks_rsp_word_q, ks_rsp_word_d;
  logic                   ks_rsp_valid_q, ks_rsp_valid_d;
  logic [AES_STATE_W-1:0] st_rsp_state_q, st_rsp_state_d;
  logic                   st_rsp_valid_q, st_rsp_valid_d;

  logic                   idle;
  logic                   ks_win;
  logic                   st_win;
  logic [AES_WORD_W-1:0]  st_word;
  logic [AES_WORD_W-1:0]  sbox_in;
  logic [AES_WORD_W-1:0]  sbox_out;

  // rr_q = 1 means the cipher port is favoured on the next tie.
  assign idle         = (state_q == FSM_IDLE);
  assign ks_win       = ks_req_valid & (~st_req_valid | KS_STRICT_PRI | ~rr_q);
  assign st_win       = st_req_valid & ~ks_win;
  assign ks_req_ready = idle & ks_win;
  assign st_req_ready = idle & st_win;

  always_comb begin
    st_word = '0;
    for (int w = 0; w < AES_NWORDS; w++) begin
      if (idx_q == 2'(w)) st_word = st_buf_q[AES_STATE_W-AES_WORD_W*(w+1) +: AES_WORD_W];
    end
  end

  // The S-box only ever sees registered operands, never the request inputs.
  assign sbox_in = (state_q == FSM_KS) ? ks_op_q : st_word;

  subword_scheduler_sbox u_sbox (
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rr_d           = rr_q;
    ks_op_d        = ks_op_q;
    st_buf_d       = st_buf_q;
    ks_rsp_word_d  = ks_rsp_word_q;
    st_rsp_state_d = st_rsp_state_q;
    ks_rsp_valid_d = 1'b0;
    st_rsp_valid_d = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        if (ks_req_ready) begin
          ks_op_d = ks_word;
          rr_d    = 1'b1;
          state_d = FSM_KS;
        end else if (st_req_ready) begin
          st_buf_d = st_state;
          idx_d    = 2'd0;
          rr_d     = 1'b0;
          state_d  = FSM_ST;
        end
      end
      FSM_KS: begin
        ks_rsp_word_d  = sbox_out;
        ks_rsp_valid_d = 1'b1;
        state_d        = FSM_IDLE;
      end
      FSM_ST: begin
        for (int w = 0; w < AES_NWORDS; w++) begin
          if (idx_q == 2'(w)) st_buf_d[AES_STATE_W-AES_WORD_W*(w+1) +: AES_WORD_W] = sbox_out;
        end
        if (idx_q == 2'(AES_NWORDS - 1)) begin
          st_rsp_state_d = st_buf_d;
          st_rsp_valid_d = 1'b1;
          idx_d          = 2'd0;
          state_d        = FSM_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FSM_IDLE;
      idx_q          <= 2'd0;
      rr_q           <= RR_INIT;
      ks_op_q        <= '0;
      st_buf_q       <= '0;
      ks_rsp_word_q  <= '0;
      ks_rsp_valid_q <= 1'b0;
      st_rsp_state_q <= '0;
      st_rsp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rr_q           <= rr_d;
      ks_op_q        <= ks_op_d;
      st_buf_q       <= st_buf_d;
      ks_rsp_word_q  <= ks_rsp_word_d;
      ks_rsp_valid_q <= ks_rsp_valid_d;
      st_rsp_state_q <= st_rsp_state_d;
      st_rsp_valid_q <= st_rsp_valid_d;
    end
  end

  assign ks_rsp_valid = ks_rsp_valid_q;
  assign ks_rsp_word  = ks_rsp_word_q;
  assign st_rsp_valid = st_rsp_valid_q;
  assign st_rsp_state = st_rsp_state_q;
  assign busy         = ~idle;

endmodule

// File: tb/tb_subword_scheduler.sv
// Directed bench for subword_scheduler: table-based S-box reference model,
// expected-response queues and latency / arbitration checks.
module tb_subword_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ks_req_valid = 1'b0, ks_req_ready;
  logic [31:0]  ks_word = '0, ks_rsp_word;
  logic         ks_rsp_valid;
  logic         st_req_valid = 1'b0, st_req_ready;
  logic [127:0] st_state = '0, st_rsp_state;
  logic         st_rsp_valid, busy;

  logic         sp_ks_req_valid = 1'b0, sp_ks_req_ready;
  logic [31:0]  sp_ks_word = '0, sp_ks_rsp_word;
  logic         sp_ks_rsp_valid;
  logic         sp_st_req_valid = 1'b0, sp_st_req_ready;
  logic [127:0] sp_st_state = '0, sp_st_rsp_state;
  logic         sp_st_rsp_valid, sp_busy;

  subword_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_word(ks_word),
    .ks_rsp_valid(ks_rsp_valid), .ks_rsp_word(ks_rsp_word),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_state(st_state),
    .st_rsp_valid(st_rsp_valid), .st_rsp_state(st_rsp_state), .busy(busy)
  );

  subword_scheduler #(.KS_STRICT_PRI(1'b1)) dut_sp (
    .clk(clk), .rst_n(rst_n),
    .ks_req_valid(sp_ks_req_valid), .ks_req_ready(sp_ks_req_ready), .ks_word(sp_ks_word),
    .ks_rsp_valid(sp_ks_rsp_valid), .ks_rsp_word(sp_ks_rsp_word),
    .st_req_valid(sp_st_req_valid), .st_req_ready(sp_st_req_ready), .st_state(sp_st_state),
    .st_rsp_valid(sp_st_rsp_valid), .st_rsp_state(sp_st_rsp_state), .busy(sp_busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference S-box table
  logic [0:255][7:0] sbox_rom;

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_rom[w[31:24]], sbox_rom[w[23:16]], sbox_rom[w[15:8]], sbox_rom[w[7:0]]};
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] s);
    return {subword(s[127:96]), subword(s[95:64]), subword(s[63:32]), subword(s[31:0])};
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  logic [31:0]  exp_ks_q[$];
  logic [127:0] exp_st_q[$];
  logic [31:0]  exp_sp_q[$];
  int ks_rsp_cnt = 0, st_rsp_cnt = 0, ks_rsp_cyc = 0, st_rsp_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (ks_rsp_valid) begin
      if (exp_ks_q.size() == 0) check("ks_unexpected_rsp", 1'b1, 1'b0);
      else check("ks_rsp_word", ks_rsp_word, exp_ks_q.pop_front());
      ks_rsp_cnt++;
      ks_rsp_cyc = cyc;
    end
    if (st_rsp_valid) begin
      if (exp_st_q.size() == 0) check("st_unexpected_rsp", 1'b1, 1'b0);
      else check("st_rsp_state", st_rsp_state, exp_st_q.pop_front());
      st_rsp_cnt++;
      st_rsp_cyc = cyc;
    end
    if (sp_ks_rsp_valid) begin
      if (exp_sp_q.size() == 0) check("sp_ks_unexpected_rsp", 1'b1, 1'b0);
      else check("sp_ks_rsp_word", sp_ks_rsp_word, exp_sp_q.pop_front());
    end
    if (sp_st_rsp_valid) check("sp_st_unexpected_rsp", 1'b1, 1'b0);
  end

  // Driver tasks: return just after the accepting edge
  task automatic ks_send(input logic [31:0] w, output int acc);
    int k = 0;
    acc = -1;
    ks_word = w;
    ks_req_valid = 1'b1;
    while (acc < 0 && k < 20) begin
      @(negedge clk);
      if (ks_req_ready) begin
        acc = cyc;
        exp_ks_q.push_back(subword(w));
      end
      @(posedge clk); #1;
      k++;
    end
    ks_req_valid = 1'b0;
    check("ks_accepted", acc >= 0, 1'b1);
  endtask

  task automatic st_send(input logic [127:0] s, output int acc);
    int k = 0;
    acc = -1;
    st_state = s;
    st_req_valid = 1'b1;
    while (acc < 0 && k < 20) begin
      @(negedge clk);
      if (st_req_ready) begin
        acc = cyc;
        exp_st_q.push_back(subbytes(s));
      end
      @(posedge clk); #1;
      k++;
    end
    st_req_valid = 1'b0;
    check("st_accepted", acc >= 0, 1'b1);
  endtask

  task automatic wait_ks(input int n0);
    int k = 0;
    while (ks_rsp_cnt == n0 && k < 20) begin @(negedge clk); k++; end
    check("ks_rsp_arrived", ks_rsp_cnt > n0, 1'b1);
  endtask

  task automatic wait_st(input int n0);
    int k = 0;
    while (st_rsp_cnt == n0 && k < 20) begin @(negedge clk); k++; end
    check("st_rsp_arrived", st_rsp_cnt > n0, 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_ks_q.size() != 0 || exp_st_q.size() != 0 || exp_sp_q.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, viol, hold_bad, gap_bad, last, sp_ks_g, sp_st_g;
    int g_q[$];
    int gc_q[$];
    logic [31:0] hold_exp;

    sbox_rom = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Reset state
    @(negedge clk);
    check("reset_ctrl", {ks_req_ready, ks_rsp_valid, st_req_ready, st_rsp_valid, busy}, 5'b0);
    check("reset_data", {ks_rsp_word, st_rsp_state[95:0]}, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after reset: ks, then st, then ks again
    viol = 0;
    ks_word = $urandom; ks_req_valid = 1'b1;
    st_state = {$urandom, $urandom, $urandom, $urandom}; st_req_valid = 1'b1;
    for (int c = 0; c < 40 && g_q.size() < 3; c++) begin
      logic ka, sa;
      @(negedge clk);
      ka = ks_req_ready;
      sa = st_req_ready;
      if (busy && (ka || sa)) viol++;
      if (ka && sa) viol++;
      if (ka) begin exp_ks_q.push_back(subword(ks_word)); g_q.push_back(0); gc_q.push_back(cyc); end
      if (sa) begin exp_st_q.push_back(subbytes(st_state)); g_q.push_back(1); gc_q.push_back(cyc); end
      @(posedge clk); #1;
      if (ka) ks_word = $urandom;
      if (sa) st_state = {$urandom, $urandom, $urandom, $urandom};
    end
    ks_req_valid = 1'b0;
    st_req_valid = 1'b0;
    check("tie_grant_count", g_q.size(), 3);
    check("tie_grant_order", {g_q[0][0], g_q[1][0], g_q[2][0]}, 3'b010);
    check("tie_st_next_idle", gc_q[1] - gc_q[0], 2);
    check("tie_ks_after_st", gc_q[2] - gc_q[1], 5);
    check("ready_rules", viol, 0);
    drain();

    // Single ks request
    busy_cnt = 0;
    n0 = ks_rsp_cnt;
    ks_send(32'h0001FF53, acc);
    wait_ks(n0);
    check("ks_known_vector", ks_rsp_word, 32'h637C16ED);
    check("ks_latency", ks_rsp_cyc - acc, 2);
    check("ks_busy_cycles", busy_cnt, 1);
    @(posedge clk); #1;

    // Single st request
    busy_cnt = 0;
    n0 = st_rsp_cnt;
    st_send({4{32'h00112233}}, acc);
    wait_st(n0);
    check("st_known_vector", st_rsp_state, {4{32'h638293C3}});
    check("st_latency", st_rsp_cyc - acc, 5);
    check("st_busy_cycles", busy_cnt, 4);
    @(posedge clk); #1;

    // st arrives during a ks op; ks response must hold through the st op
    hold_exp = subword(32'hDEADBEEF);
    ks_send(32'hDEADBEEF, acc);
    st_state = {$urandom, $urandom, $urandom, $urandom};
    st_req_valid = 1'b1;
    @(negedge clk);
    check("st_ready_during_ks", st_req_ready, 1'b0);
    check("busy_during_ks", busy, 1'b1);
    @(negedge clk);
    check("st_ready_in_idle", st_req_ready, 1'b1);
    if (st_req_ready) exp_st_q.push_back(subbytes(st_state));
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    hold_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ks_rsp_word !== hold_exp) hold_bad++;
    end
    check("ks_rsp_hold", hold_bad, 0);
    drain();

    // Strict priority: ks held valid starves st, accepted every 2 cycles
    gap_bad = 0; last = -1; sp_ks_g = 0; sp_st_g = 0;
    sp_ks_word = $urandom; sp_ks_req_valid = 1'b1;
    sp_st_state = {$urandom, $urandom, $urandom, $urandom}; sp_st_req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      logic ka;
      @(negedge clk);
      ka = sp_ks_req_ready;
      if (sp_st_req_ready) sp_st_g++;
      if (ka) begin
        exp_sp_q.push_back(subword(sp_ks_word));
        if (last >= 0 && cyc - last != 2) gap_bad++;
        last = cyc;
        sp_ks_g++;
      end
      @(posedge clk); #1;
      if (ka) sp_ks_word = $urandom;
    end
    sp_ks_req_valid = 1'b0;
    sp_st_req_valid = 1'b0;
    check("sp_st_never_granted", sp_st_g, 0);
    check("sp_ks_grant_count", sp_ks_g, 10);
    check("sp_ks_every_2", gap_bad, 0);
    drain();

    // Reset while ST is at idx 2
    n0 = st_rsp_cnt;
    st_send({$urandom, $urandom, $urandom, $urandom}, acc);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(exp_st_q.pop_back());
    @(negedge clk);
    check("rst_mid_ctrl", {ks_req_ready, ks_rsp_valid, st_req_ready, st_rsp_valid, busy}, 5'b0);
    check("rst_mid_ks_word", ks_rsp_word, 32'h0);
    check("rst_mid_st_state", st_rsp_state, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_st_pulse", st_rsp_cnt, n0);
    @(posedge clk); #1;
    n0 = ks_rsp_cnt;
    ks_send(32'hC0FFEE01, acc);
    wait_ks(n0);
    check("post_rst_ks_latency", ks_rsp_cyc - acc, 2);
    drain();

    check("ks_queue_empty", exp_ks_q.size(), 0);
    check("st_queue_empty", exp_st_q.size(), 0);
    check("sp_queue_empty", exp_sp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
